// File: rtl/usb_txn_ctrl_if.sv
// Request/response and output/input pipe bundle for usb_txn_ctrl.
// master = host model + pipes, slave = the transaction controller.
interface usb_txn_ctrl_if;
  logic        req_valid;
  logic        req_is_in;
  logic [6:0]  req_addr;
  logic [3:0]  req_endp;
  logic [63:0] req_data;
  logic        req_ready;
  logic        done;
  logic        success;
  logic [63:0] rsp_data;
  logic [3:0]  out_pid;
  logic [6:0]  out_addr;
  logic [3:0]  out_endp;
  logic [63:0] out_data;
  logic        out_pktready;
  logic        out_done;
  logic        writing;
  logic        in_pktready;
  logic        in_error;
  logic        in_ack;
  logic        in_nak;
  logic [63:0] in_data;

  modport master (
    output req_valid, req_is_in, req_addr, req_endp, req_data,
    output out_done, in_pktready, in_error, in_ack, in_nak, in_data,
    input  req_ready, done, success, rsp_data,
    input  out_pid, out_addr, out_endp, out_data, out_pktready, writing
  );

  modport slave (
    input  req_valid, req_is_in, req_addr, req_endp, req_data,
    input  out_done, in_pktready, in_error, in_ack, in_nak, in_data,
    output req_ready, done, success, rsp_data,
    output out_pid, out_addr, out_endp, out_data, out_pktready, writing
  );
endinterface

// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: token/data/handshake, response timeout, retries.
// Optional feature macro: USB_TXN_DATA_TOGGLE_EN (DATA0/DATA1 toggle tracking).
module usb_txn_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 8
) (
  input logic           clk,
  input logic           rst_L,
  usb_txn_ctrl_if.slave bus
);
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;

  typedef enum logic [3:0] {
    S_IDLE, S_TOKEN, S_TOKEN_WAIT, S_DATA, S_DATA_WAIT, S_HS_WAIT,
    S_RX_WAIT, S_SEND_ACK, S_ACK_WAIT, S_RETRY, S_DONE
  } state_t;

  state_t      r_state;
  logic        r_is_in;
  logic [6:0]  r_addr;
  logic [3:0]  r_endp;
  logic [63:0] r_data;
  logic [3:0]  r_att;
  logic [8:0]  r_tmo;
  logic        r_ok;
  logic        r_req_ready;
  logic        r_done;
  logic        r_success;
  logic        r_pktready;
  logic        r_writing;
  logic [3:0]  r_pid;
  logic [6:0]  r_oaddr;
  logic [3:0]  r_oendp;
  logic [63:0] r_odata;
  logic [63:0] r_rsp;

  logic        w_tmo_hit;
  logic        w_last;
  state_t      w_fail_nxt;
  logic [3:0]  w_data_pid;

`ifdef USB_TXN_DATA_TOGGLE_EN
  logic r_toggle;
  assign w_data_pid = r_toggle ? PID_DATA1 : PID_DATA0;
`else
  assign w_data_pid = PID_DATA0;
`endif

  assign w_tmo_hit  = (r_tmo == 9'(TIMEOUT));
  assign w_last     = (r_att == 4'(MAX_RETRY));
  // Exhaustion is decided in the wait state so a final failure reports as fast as a success.
  assign w_fail_nxt = w_last ? S_DONE : S_RETRY;

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      r_state     <= S_IDLE;
      r_is_in     <= 1'b0;
      r_addr      <= '0;
      r_endp      <= '0;
      r_data      <= '0;
      r_att       <= '0;
      r_tmo       <= '0;
      r_ok        <= 1'b0;
      r_req_ready <= 1'b1;
      r_done      <= 1'b0;
      r_success   <= 1'b0;
      r_pktready  <= 1'b0;
      r_writing   <= 1'b0;
      r_pid       <= '0;
      r_oaddr     <= '0;
      r_oendp     <= '0;
      r_odata     <= '0;
      r_rsp       <= '0;
`ifdef USB_TXN_DATA_TOGGLE_EN
      r_toggle    <= 1'b0;
`endif
    end else begin
      r_pktready <= 1'b0;
      r_done     <= 1'b0;
      r_success  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_is_in     <= bus.req_is_in;
            r_addr      <= bus.req_addr;
            r_endp      <= bus.req_endp;
            r_data      <= bus.req_data;
            r_att       <= 4'd1;
            r_ok        <= 1'b0;
            r_writing   <= 1'b1;
            r_state     <= S_TOKEN;
          end
        end
        S_TOKEN: begin
          r_pid      <= r_is_in ? PID_IN : PID_OUT;
          r_oaddr    <= r_addr;
          r_oendp    <= r_endp;
          r_pktready <= 1'b1;
          r_state    <= S_TOKEN_WAIT;
        end
        S_TOKEN_WAIT: if (bus.out_done) begin
          r_tmo <= '0;
          if (r_is_in) begin
            r_writing <= 1'b0;
            r_state   <= S_RX_WAIT;
          end else begin
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          r_pid      <= w_data_pid;
          r_odata    <= r_data;
          r_pktready <= 1'b1;
          r_state    <= S_DATA_WAIT;
        end
        S_DATA_WAIT: if (bus.out_done) begin
          r_tmo     <= '0;
          r_writing <= 1'b0;
          r_state   <= S_HS_WAIT;
        end
        S_HS_WAIT: begin
          r_tmo <= r_tmo + 9'd1;
          if (bus.in_error || bus.in_nak || bus.in_pktready) begin
            r_state <= w_fail_nxt;
          end else if (bus.in_ack) begin
            r_ok    <= 1'b1;
            r_state <= S_DONE;
`ifdef USB_TXN_DATA_TOGGLE_EN
            r_toggle <= ~r_toggle;
`endif
          end else if (w_tmo_hit) begin
            r_state <= w_fail_nxt;
          end
        end
        S_RX_WAIT: begin
          r_tmo <= r_tmo + 9'd1;
          if (bus.in_error || bus.in_nak) begin
            r_state <= w_fail_nxt;
          end else if (bus.in_pktready) begin
            r_rsp     <= bus.in_data;
            r_ok      <= 1'b1;
            r_writing <= 1'b1;
            r_state   <= S_SEND_ACK;
`ifdef USB_TXN_DATA_TOGGLE_EN
            r_toggle <= ~r_toggle;
`endif
          end else if (w_tmo_hit) begin
            r_state <= w_fail_nxt;
          end
        end
        S_SEND_ACK: begin
          r_pid      <= PID_ACK;
          r_pktready <= 1'b1;
          r_state    <= S_ACK_WAIT;
        end
        S_ACK_WAIT: if (bus.out_done) begin
          r_writing <= 1'b0;
          r_state   <= S_DONE;
        end
        S_RETRY: begin
          r_att     <= r_att + 4'd1;
          r_writing <= 1'b1;
          r_state   <= S_TOKEN;
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_success <= r_ok;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.done         = r_done;
  assign bus.success      = r_success;
  assign bus.rsp_data     = r_rsp;
  assign bus.out_pid      = r_pid;
  assign bus.out_addr     = r_oaddr;
  assign bus.out_endp     = r_oendp;
  assign bus.out_data     = r_odata;
  assign bus.out_pktready = r_pktready;
  assign bus.writing      = r_writing;
endmodule

// File: doc/usb_txn_ctrl.md
# usb_txn_ctrl

Host-side transaction sequencer for the USB link. It accepts one OUT or IN transaction request at a time and drives the output pipe with the token, data and handshake packets. It switches bus direction to the input pipe for the device response, then applies timeout and retry policy. It sits between the host software model and the output/input pipe pair, and reports a single pass/fail completion per request.

## Interface
- `TIMEOUT`, default 255: cycles to wait for a device response before counting a failed attempt.
- `MAX_RETRY`, default 8: total attempts per transaction, including the first.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_L` in 1: reset, synchronous and active-low.
- `req_valid` in 1: a request is presented.
- `req_is_in` in 1: 1 = IN transaction, 0 = OUT transaction.
- `req_addr` in 7 and `req_endp` in 4: device address and endpoint.
- `req_data` in 64: OUT payload.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid` and `req_ready` are both high.
- `done` out 1: one-cycle pulse when the transaction finishes.
- `success` out 1: result, valid while `done` is high.
- `rsp_data` out 64: IN payload, held until the next accepted IN transaction.
- `out_pid` out 4, `out_addr` out 7, `out_endp` out 4, `out_data` out 64: packet fields to the output pipe.
- `out_pktready` out 1: one-cycle launch strobe to the output pipe.
- `out_done` in 1: one-cycle pulse from the output pipe at end of packet (EOP).
- `writing` out 1: bus direction, 1 = output pipe owns the bus.
- `in_pktready`, `in_error`, `in_ack`, `in_nak` in 1 each: one-cycle strobes from the input pipe.
- `in_data` in 64: received payload, valid with `in_pktready`.

## Operation
PID encodings:
- OUT = 0001, IN = 1001, DATA0 = 0011, DATA1 = 1011, ACK = 0010.

States and transitions:
- **IDLE**: `req_ready` is 1. On accept, latch the request, set attempt count to 1, go to TOKEN.
- **TOKEN**:
  - Drive `out_pid` = OUT or IN, plus `out_addr`/`out_endp`.
  - Pulse `out_pktready` for one cycle, go to TOKEN_WAIT.
- **TOKEN_WAIT**: on `out_done`:
  - OUT transaction: go to DATA.
  - IN transaction: go to RX_WAIT.
- **DATA** (OUT only): drive DATA PID and `out_data` = latched payload, pulse `out_pktready`, go to DATA_WAIT.
- **DATA_WAIT**: on `out_done`, go to HS_WAIT.
- **HS_WAIT** (OUT only):
  - `in_ack`: go to DONE with success.
  - `in_nak`, `in_error`, `in_pktready`, or timeout: go to RETRY.
- **RX_WAIT** (IN only):
  - `in_pktready` with `in_error` = 0: capture `in_data` into `rsp_data`, go to SEND_ACK.
  - `in_nak`, `in_error`, or timeout: go to RETRY; no handshake is sent.
- **SEND_ACK**: `out_pid` = ACK, pulse `out_pktready`, go to ACK_WAIT.
- **ACK_WAIT**: on `out_done`, go to DONE with success.
- **RETRY**:
  - If attempts == `MAX_RETRY`: go to DONE with fail.
  - Otherwise increment attempts and go to TOKEN.
- **DONE**: pulse `done` with `success`, go to IDLE.

Bus direction:
- `writing` = 1 in TOKEN, TOKEN_WAIT, DATA, DATA_WAIT, SEND_ACK and ACK_WAIT.
- `writing` = 0 in all other states.

Precedence rules:
- `in_error` overrides any other strobe in the same cycle.
- Input-pipe strobes arriving in states other than HS_WAIT/RX_WAIT are ignored.

Counters:
- Timeout counter is 9 bits; it clears on entry to HS_WAIT/RX_WAIT and increments every cycle in those states.
- Timeout fires on the cycle the count equals `TIMEOUT`, provided no strobe arrives that cycle.
- Attempt counter is 4 bits; `MAX_RETRY` must be between 1 and 15.

## Timing
Reset values (`rst_L` sampled low at a clock edge):
- State = IDLE.
- `req_ready` = 1; `done`, `success`, `out_pktready`, `writing` = 0.
- `out_pid`/`out_addr`/`out_endp`/`out_data`/`rsp_data` = 0.
- Data toggle = DATA0.
- Attempt and timeout counters = 0.

Latencies:
- Request accepted at edge N: `out_pktready` is high in cycle N+1.
- `out_done` in cycle M: the next `out_pktready` (DATA) is high in cycle M+2.
- Decisive strobe or timeout in cycle K: `done` is high in cycle K+2, `req_ready` in cycle K+3.

Handshake and hold rules:
- `out_*` fields hold stable from the `out_pktready` cycle until `out_done`.
- Reset mid-transaction aborts immediately: `writing` drops to 0 on the next edge and no `done` is issued.

## Configuration
`USB_TXN_DATA_TOGGLE_EN`:
- **Defined**: the controller keeps one toggle bit.
  - OUT DATA packets use DATA0/DATA1 per the toggle; the toggle flips on each successful OUT.
  - For IN, the toggle flips when a received packet is accepted.
  - Retries resend the same toggle value.
- **Undefined**: every DATA packet is DATA0 and no toggle state exists.

## Test plan
- OUT, addr 5, endp 2, data 64'hDEADBEEF_01234567; device ACKs.
  - Expect `out_pid` sequence 0001 then 0011.
  - Expect `done`=1, `success`=1, and `writing`=0 during HS_WAIT.
- IN, addr 3, endp 1; input pipe returns `in_data`=64'h0123 with `in_pktready`.
  - Expect `rsp_data`=64'h0123, ACK PID 0010 sent, `success`=1.
- OUT with device NAK twice, then ACK.
  - Expect 3 token launches and `success`=1.
- IN with no response at all, `TIMEOUT`=20, `MAX_RETRY`=3.
  - Expect 3 token launches spaced by the 20-cycle waits.
  - Expect `done` 2 cycles after the third timeout with `success`=0.
- `in_ack` and `in_error` in the same HS_WAIT cycle: expect a retry.
- `rst_L` low during DATA_WAIT: expect IDLE, `writing`=0, no `done`.
- With `USB_TXN_DATA_TOGGLE_EN`: two successful OUTs use DATA PIDs 0011 then 1011.
